list_builder: RTL
=================

LIST_BUILDER -- requirements
Module: list_builder

Interface
REQ-001 SHALL have parameter BASE, default 8'h00, byte address of the first node; it must be even.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin a new list at BASE; honoured only in IDLE.
REQ-005 SHALL have ports in_valid input 1, in_data input 8, in_last input 1, and in_ready output 1, which form a valid/ready element stream.
REQ-006 SHALL have ports mem_we output 1, mem_addr output 8 and mem_wdata output 8, which form a byte RAM write port with one write per cycle.
REQ-007 SHALL have ports head output 8 (list head, 8'hFF when empty), count output 8 (nodes written), busy output 1, done output 1 (one-cycle pulse), overflow output 1 (sticky) and sum output 8.

Function
REQ-008 SHALL write each node at address p as follows: RAM[p] = next pointer and RAM[p+1] = data; 8'hFF is the null pointer.
REQ-009 SHALL allocate nodes sequentially: node k at BASE+2k, with next pointer BASE+2(k+1), or 8'hFF for the terminal node.
REQ-010 SHALL implement FSM states IDLE, ACCEPT, WR_DATA, WR_NEXT and DRAIN.
REQ-011 SHALL, in IDLE with start=1, go to ACCEPT and clear count, overflow and sum, set cur=BASE, and set head=8'hFF.
REQ-012 SHALL drive in_ready=1 only in ACCEPT and DRAIN; a handshake is in_valid && in_ready at a rising edge.
REQ-013 SHALL, on a handshake in ACCEPT, latch in_data and the terminal flag and go to WR_DATA.
  - terminal flag = in_last OR (cur == 8'hFE).
REQ-014 SHALL, in WR_DATA, drive mem_we=1, mem_addr=cur+1 and mem_wdata=latched data, then go to WR_NEXT.
REQ-015 SHALL, in WR_NEXT, drive mem_we=1, mem_addr=cur and mem_wdata = terminal ? 8'hFF : cur+2, and update state at the clock edge ending the cycle:
  - increment count; if count was 0, set head=BASE;
  - if terminal: pulse done for one cycle and go to IDLE, except when the overflow case applies (go to DRAIN, REQ-016);
  - otherwise: set cur=cur+2 and go to ACCEPT.
REQ-016 SHALL handle overflow when the node at 8'hFE is forced terminal while in_last was 0:
  - set overflow=1 and go to DRAIN;
  - DRAIN accepts and discards elements without writing;
  - on the handshake with in_last=1, pulse done and go to IDLE.
REQ-017 SHALL give a latency of 3 cycles per element (handshake, WR_DATA, WR_NEXT) and a throughput of 1 element per 3 cycles.
REQ-018 SHALL drive mem_we=0 in every state other than WR_DATA and WR_NEXT.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL keep head, count, overflow and sum stable in IDLE until the next start.

Reset
REQ-022 SHALL, on rst=1 at an edge, go to IDLE and set cur=BASE, head=8'hFF, count=0, overflow=0, sum=0, done=0 and in_ready=0; mem_we SHALL be 0 from the following cycle.
REQ-023 SHALL allow reset mid-list: nodes already written remain in RAM untouched, and no terminator is written.
REQ-024 SHALL give rst priority over start.

Configuration
REQ-025 SHALL, with LIST_BUILDER_SUM_EN defined, accumulate sum = sum + data (8-bit, wrapping) in WR_NEXT for every node written; discarded DRAIN data is not added.
REQ-026 SHALL, without LIST_BUILDER_SUM_EN, tie sum to 8'h00 and synthesise no accumulator.

Structure
REQ-027 SHALL take its shared definitions from package list_pkg: typedefs addr8_t and data8_t, constant NULLPTR = 8'hFF, and the node field offsets NEXT_OFS=0 and DATA_OFS=1.
REQ-028 SHALL be implemented as a single module with no sub-modules; the FSM and datapath are small.

Verification
REQ-029 SHALL pass this scenario: BASE=0, start, then 3, 5, 7 with in_last on 7 -> RAM[0..5] = 02,03,04,05,FF,07; head=00; count=3; done pulses once; sum=0F with LIST_BUILDER_SUM_EN.
REQ-030 SHALL pass this scenario: BASE=0x10, single element 0xAA with in_last -> RAM[0x10]=FF, RAM[0x11]=AA; head=10; count=1.
REQ-031 SHALL pass this scenario: BASE=0xFC, 4 elements, last not flagged until the 4th -> RAM[FC..FF] = FE,e0,FF,e1; count=2; overflow=1; done pulses after the 4th handshake.
REQ-032 SHALL pass this scenario: in_valid toggling 1/0 every cycle -> each element accepted only in ACCEPT; mem_we high exactly 2 cycles per element; no duplicate or lost elements.
REQ-033 SHALL pass this scenario: rst asserted during WR_DATA of element 2 -> next cycle busy=0, head=FF, count=0, mem_we=0; a new start rebuilds from BASE.
REQ-034 SHALL pass this scenario: start pulsed during ACCEPT -> ignored; list continues unchanged; build a list, traverse it from head with a reference walker, and the walker's sum matches.

Source files
------------

// File: rtl/list_pkg.sv
// Shared types and constants for the linked-list builder.
// Nodes are two bytes: next pointer at offset 0, data at offset 1.
package list_pkg;

  typedef logic [7:0] addr8_t;
  typedef logic [7:0] data8_t;

  localparam addr8_t NULLPTR  = 8'hFF;
  localparam addr8_t NEXT_OFS = 8'd0;
  localparam addr8_t DATA_OFS = 8'd1;
  localparam addr8_t LAST_NODE = 8'hFE;
  localparam addr8_t NODE_SZ  = 8'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WR_DATA,
    S_WR_NEXT,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/list_builder.sv
// Streams elements into a singly linked list in a byte RAM.
// Define LIST_BUILDER_SUM_EN to keep a running sum of node data.
module list_builder
  import list_pkg::*;
#(
  parameter addr8_t BASE = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         mem_we,
  output logic [7:0]   mem_addr,
  output logic [7:0]   mem_wdata,
  output logic [7:0]   head,
  output logic [7:0]   count,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [7:0]   sum
);

  state_t state;
  addr8_t cur;
  data8_t data_q;
  logic   term_q;
  logic   last_q;

`ifdef LIST_BUILDER_SUM_EN
  data8_t sum_q;
  assign sum = sum_q;
`else
  assign sum = 8'h00;
`endif

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state    <= S_IDLE;
      cur      <= BASE;
      head     <= NULLPTR;
      count    <= 8'd0;
      overflow <= 1'b0;
      data_q   <= 8'h00;
      term_q   <= 1'b0;
      last_q   <= 1'b0;
`ifdef LIST_BUILDER_SUM_EN
      sum_q    <= 8'h00;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          state    <= S_ACCEPT;
          count    <= 8'd0;
          overflow <= 1'b0;
          cur      <= BASE;
          head     <= NULLPTR;
`ifdef LIST_BUILDER_SUM_EN
          sum_q    <= 8'h00;
`endif
        end
        S_ACCEPT: if (in_valid) begin
          data_q <= in_data;
          last_q <= in_last;
          // the top-of-RAM node cannot link anywhere
          term_q <= in_last | (cur == LAST_NODE);
          state  <= S_WR_DATA;
        end
        S_WR_DATA: state <= S_WR_NEXT;
        S_WR_NEXT: begin
          count <= count + 8'd1;
          if (count == 8'd0) head <= BASE;
`ifdef LIST_BUILDER_SUM_EN
          sum_q <= sum_q + data_q;
`endif
          if (term_q && !last_q) begin
            overflow <= 1'b1;
            state    <= S_DRAIN;
          end else if (term_q) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cur   <= cur + NODE_SZ;
            state <= S_ACCEPT;
          end
        end
        S_DRAIN: if (in_valid && in_last) begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cur + NEXT_OFS;
    mem_wdata = 8'h00;
    unique case (1'b1)
      (state == S_ACCEPT),
      (state == S_DRAIN): in_ready = 1'b1;
      (state == S_WR_DATA): begin
        mem_we    = 1'b1;
        mem_addr  = cur + DATA_OFS;
        mem_wdata = data_q;
      end
      (state == S_WR_NEXT): begin
        mem_we    = 1'b1;
        mem_wdata = term_q ? NULLPTR : cur + NODE_SZ;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
